// File: rtl/field_mux_n_if.sv
// Handshake and data bundle for field_mux_n: start/select/operands in, ready/strobe/result out.
`ifndef F_NBITS
`define F_NBITS 16
`endif

interface field_mux_n_if #(
    parameter int NINPUTS  = 4,
    parameter int SEL_BITS = $clog2(NINPUTS)
);
    logic                         en_i;
    logic [SEL_BITS-1:0]          sel_i;
    logic [NINPUTS*`F_NBITS-1:0]  in_i;
    logic                         ready_o;
    logic                         ready_pulse_o;
    logic [`F_NBITS-1:0]          c_o;
    logic                         sel_err_o;

    modport master (
        output en_i, sel_i, in_i,
        input  ready_o, ready_pulse_o, c_o, sel_err_o
    );

    modport slave (
        input  en_i, sel_i, in_i,
        output ready_o, ready_pulse_o, c_o, sel_err_o
    );
endinterface

// File: rtl/field_mux_n.sv
// N-input field-element selector with a LATENCY-stage valid-tracked pipeline and edge-triggered start.
// Optional select range checking: define FIELD_MUX_N_SELCHK_EN.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module field_mux_n #(
    parameter int NINPUTS  = 4,
    parameter int SEL_BITS = $clog2(NINPUTS),
    parameter int LATENCY  = 1
) (
    input  logic         clk,
    input  logic         rst,
    field_mux_n_if.slave bus
);
    localparam int F_W      = `F_NBITS;
    localparam int NSLOTS   = 1 << SEL_BITS;
    localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    logic                en_dly_q, en_dly_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [LATENCY-1:0]  err_q, err_d;
    logic [F_W-1:0]      data_q [LATENCY];
    logic [F_W-1:0]      data_d [LATENCY];

    state_e              state_s;
    logic                start_s;
    logic [F_W-1:0]      slot_data_s [NSLOTS];
    logic [NSLOTS-1:0]   slot_err_s;
    logic [F_W-1:0]      sel_data_s;
    logic                sel_err_s;

    // Every encodable select value maps to a fixed slot, so out-of-range handling is pure wiring.
    for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
        if (k < NINPUTS) begin : g_in_range
            assign slot_data_s[k] = bus.in_i[k*F_W +: F_W];
            assign slot_err_s[k]  = 1'b0;
        end else begin : g_out_range
`ifdef FIELD_MUX_N_SELCHK_EN
            assign slot_data_s[k] = '0;
            assign slot_err_s[k]  = 1'b1;
`else
            assign slot_data_s[k] = bus.in_i[(NINPUTS-1)*F_W +: F_W];
            assign slot_err_s[k]  = 1'b0;
`endif
        end
    end

    assign sel_data_s = slot_data_s[bus.sel_i];
    assign sel_err_s  = slot_err_s[bus.sel_i];

    assign state_s = (cnt_q == '0) ? ST_IDLE : ST_BUSY;
    assign start_s = bus.en_i & ~en_dly_q & (state_s == ST_IDLE);

    // Next-state logic: latency counter, edge detector and pipeline stage advance.
    always_comb begin
        en_dly_d = bus.en_i;
        cnt_d    = cnt_q;
        vld_d    = '0;
        err_d    = err_q;
        for (int k = 0; k < LATENCY; k++) begin
            data_d[k] = data_q[k];
        end

        if (start_s) begin
            cnt_d = CNT_INIT;
        end else if (state_s == ST_BUSY) begin
            cnt_d = cnt_q - CNT_BITS'(1);
        end else begin
            cnt_d = cnt_q;
        end

        vld_d[0] = start_s;
        if (start_s) begin
            data_d[0] = sel_data_s;
            err_d[0]  = sel_err_s;
        end else begin
            data_d[0] = data_q[0];
            err_d[0]  = err_q[0];
        end

        // A stage only moves when its predecessor holds a valid token, so the last stage holds c.
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
                data_d[k] = data_q[k-1];
                err_d[k]  = err_q[k-1];
            end else begin
                data_d[k] = data_q[k];
                err_d[k]  = err_q[k];
            end
        end
    end

    // State registers; en_dly resets high so en already high at release does not start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_dly_q <= 1'b1;
            cnt_q    <= '0;
            vld_q    <= '0;
            err_q    <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            en_dly_q <= en_dly_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.ready_o       = ~start_s & (state_s == ST_IDLE);
    assign bus.ready_pulse_o = vld_q[LATENCY-1];
    assign bus.c_o           = data_q[LATENCY-1];
    assign bus.sel_err_o     = err_q[LATENCY-1];
endmodule

// File: tb/tb_field_mux_n.sv
// Bench for field_mux_n: three configurations driven by directed and random steps,
// checked every cycle against a transaction-level model.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module tb_field_mux_n;
    localparam int NIN [3] = '{4, 4, 5};
    localparam int LAT [3] = '{1, 3, 4};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit          en_v  [3];
    int          sel_v [3];
    logic [15:0] op    [5];

    int n_checks = 0;
    int n_err    = 0;

    // model state
    int          cyc = 0;
    bit          en_prev    [3];
    int          busy_until [3];
    bit          pend_valid [3];
    int          pend_due   [3];
    logic [15:0] pend_data  [3];
    bit          pend_err   [3];
    logic [15:0] m_c        [3];
    bit          m_err      [3];
    bit          m_pulse    [3];

    field_mux_n_if #(.NINPUTS(4)) if1 ();
    field_mux_n_if #(.NINPUTS(4)) if3 ();
    field_mux_n_if #(.NINPUTS(5)) if5 ();

    assign if1.en_i  = en_v[0];
    assign if3.en_i  = en_v[1];
    assign if5.en_i  = en_v[2];
    assign if1.sel_i = 2'(sel_v[0]);
    assign if3.sel_i = 2'(sel_v[1]);
    assign if5.sel_i = 3'(sel_v[2]);
    assign if1.in_i  = {op[3], op[2], op[1], op[0]};
    assign if3.in_i  = {op[3], op[2], op[1], op[0]};
    assign if5.in_i  = {op[4], op[3], op[2], op[1], op[0]};

    field_mux_n #(.NINPUTS(4), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
    field_mux_n #(.NINPUTS(4), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if3));
    field_mux_n #(.NINPUTS(5), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if5));

    task automatic chk1(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {err, data} the selector should produce for operand index s out of n
    function automatic logic [16:0] ref_pick(int n, int s);
        if (s < n) return {1'b0, op[s]};
`ifdef FIELD_MUX_N_SELCHK_EN
        return {1'b1, 16'd0};
`else
        return {1'b0, op[n-1]};
`endif
    endfunction

    task automatic model_reset(int d);
        en_prev[d]    = 1'b1;
        busy_until[d] = 0;
        pend_valid[d] = 1'b0;
        m_c[d]        = 16'd0;
        m_err[d]      = 1'b0;
        m_pulse[d]    = 1'b0;
    endtask

    task automatic model_edge();
        bit idle;
        bit st;
        logic [16:0] r;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                model_reset(d);
            end else begin
                idle       = (cyc >= busy_until[d]);
                st         = en_v[d] && !en_prev[d] && idle;
                en_prev[d] = en_v[d];
                m_pulse[d] = 1'b0;
                if (st) begin
                    r             = ref_pick(NIN[d], sel_v[d]);
                    pend_valid[d] = 1'b1;
                    pend_due[d]   = cyc + LAT[d];
                    pend_data[d]  = r[15:0];
                    pend_err[d]   = r[16];
                    busy_until[d] = cyc + LAT[d];
                end
            end
        end
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (!rst && pend_valid[d] && pend_due[d] == cyc) begin
                m_c[d]        = pend_data[d];
                m_err[d]      = pend_err[d];
                m_pulse[d]    = 1'b1;
                pend_valid[d] = 1'b0;
            end
        end
    endtask

    task automatic check_dut(int d);
        logic rdy, pls, er;
        logic [15:0] cv;
        bit idle, st;
        case (d)
            0:       begin rdy = if1.ready_o; pls = if1.ready_pulse_o; cv = if1.c_o; er = if1.sel_err_o; end
            1:       begin rdy = if3.ready_o; pls = if3.ready_pulse_o; cv = if3.c_o; er = if3.sel_err_o; end
            default: begin rdy = if5.ready_o; pls = if5.ready_pulse_o; cv = if5.c_o; er = if5.sel_err_o; end
        endcase
        idle = rst || (cyc >= busy_until[d]);
        st   = !rst && en_v[d] && !en_prev[d] && idle;
        chk1($sformatf("d%0d_ready@%0d", d, cyc), rdy, idle && !st);
        chk1($sformatf("d%0d_pulse@%0d", d, cyc), pls, m_pulse[d]);
        chk16($sformatf("d%0d_c@%0d", d, cyc), cv, m_c[d]);
        chk1($sformatf("d%0d_selerr@%0d", d, cyc), er, m_err[d]);
    endtask

    // One clock cycle: check all DUTs mid-cycle, advance the model at the edge, return just after it.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_dut(d);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en_v[d]  = 1'b1;
            sel_v[d] = 0;
            model_reset(d);
        end
        op[0] = 16'd10; op[1] = 16'd20; op[2] = 16'd30; op[3] = 16'd40; op[4] = 16'd50;

        // reset with en high, then en held: no start
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();
        chk16("hold_c", if1.c_o, 16'd0);
        chk1("hold_ready", if1.ready_o, 1'b1);
        chk1("hold_pulse", if1.ready_pulse_o, 1'b0);

        // LATENCY=1 single select
        en_v[0] = 1'b0; en_v[1] = 1'b0; en_v[2] = 1'b0;
        step();
        sel_v[0] = 2; en_v[0] = 1'b1;
        #1 chk1("l1_ready_T", if1.ready_o, 1'b0);
        step();
        chk16("l1_c", if1.c_o, 16'd30);
        chk1("l1_pulse", if1.ready_pulse_o, 1'b1);
        chk1("l1_ready_T1", if1.ready_o, 1'b1);
        en_v[0] = 1'b0;
        step();
        chk1("l1_pulse_off", if1.ready_pulse_o, 1'b0);

        // LATENCY=3: second edge while busy is dropped
        sel_v[1] = 3; en_v[1] = 1'b1;
        step();
        en_v[1] = 1'b0;
        step();
        sel_v[1] = 0; en_v[1] = 1'b1;
        #1 chk1("l3_ready_T2", if3.ready_o, 1'b0);
        step();
        chk16("l3_c", if3.c_o, 16'd40);
        chk1("l3_pulse", if3.ready_pulse_o, 1'b1);
        en_v[1] = 1'b0;
        repeat (3) step();
        chk1("l3_no_pulse", if3.ready_pulse_o, 1'b0);
        chk16("l3_c_hold", if3.c_o, 16'd40);

        // LATENCY=3 back-to-back start in the done cycle
        sel_v[1] = 1; en_v[1] = 1'b1;
        step();
        en_v[1] = 1'b0;
        repeat (2) step();
        sel_v[1] = 0; en_v[1] = 1'b1;
        #1 chk1("b2b_ready", if3.ready_o, 1'b0);
        chk1("b2b_pulse1", if3.ready_pulse_o, 1'b1);
        chk16("b2b_c1", if3.c_o, 16'd20);
        step();
        en_v[1] = 1'b0;
        repeat (2) step();
        chk1("b2b_pulse2", if3.ready_pulse_o, 1'b1);
        chk16("b2b_c2", if3.c_o, 16'd10);

        // NINPUTS=5, out-of-range then in-range select
        sel_v[2] = 6; en_v[2] = 1'b1;
        step();
        en_v[2] = 1'b0;
        repeat (3) step();
        chk1("oor_pulse", if5.ready_pulse_o, 1'b1);
`ifdef FIELD_MUX_N_SELCHK_EN
        chk16("oor_c", if5.c_o, 16'd0);
        chk1("oor_err", if5.sel_err_o, 1'b1);
`else
        chk16("oor_c", if5.c_o, 16'd50);
        chk1("oor_err", if5.sel_err_o, 1'b0);
`endif
        sel_v[2] = 4; en_v[2] = 1'b1;
        step();
        en_v[2] = 1'b0;
        repeat (3) step();
        chk16("inr_c", if5.c_o, 16'd50);
        chk1("inr_err", if5.sel_err_o, 1'b0);

        // reset mid-operation on LATENCY=4
        sel_v[2] = 1; en_v[2] = 1'b1;
        step();
        en_v[2] = 1'b0;
        step();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) model_reset(d);
        #1 chk16("mid_rst_c", if5.c_o, 16'd0);
        chk1("mid_rst_ready", if5.ready_o, 1'b1);
        step();
        rst = 1'b0;
        step();
        chk1("mid_rst_no_pulse", if5.ready_pulse_o, 1'b0);
        chk16("mid_rst_c_after", if5.c_o, 16'd0);

        // random traffic on all three instances
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 5; k++) op[k] = 16'($urandom);
            for (int d = 0; d < 3; d++) begin
                en_v[d]  = 1'($urandom_range(0, 1));
                sel_v[d] = int'($urandom_range(0, (d == 2) ? 7 : 3));
            end
            step();
        end
        en_v[0] = 1'b0; en_v[1] = 1'b0; en_v[2] = 1'b0;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
